array_wr_ctrl: RTL and testbench

ARRAY_WR_CTRL -- requirements
Module: array_wr_ctrl

---
 rtl/array_pkg.sv | 16 +
 rtl/array_fill_cnt.sv | 43 ++++
 rtl/array_wr_ctrl.sv | 207 ++++++++++++++++++++
 tb/tb_array_wr_ctrl.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/array_pkg.sv
// array_pkg: definitions shared by the array write controller.
//   wr_state_e  - write-controller FSM state encoding
//   PAR_CLR_BIT - par_ctrl bit that requests a parity-sticky clear
//   PAR_DIS_BIT - par_ctrl bit that disables parity generation
package array_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_INIT    = 2'd1,
        ST_CPU_ACK = 2'd2
    } wr_state_e;

    localparam int PAR_CLR_BIT = 0;
    localparam int PAR_DIS_BIT = 1;

endpackage

// File: rtl/array_fill_cnt.sv
// array_fill_cnt: fill address counter for the array initialisation sweep.
//   wclk - clock (rising edge)
//   rst_ - asynchronous active-low reset, clears the count
//   en   - advance the count by one, wrapping to 0 after DEPTH-1
//   clr  - synchronous clear to address 0 (takes precedence over en)
//   cnt  - current fill address
//   wrap - high while cnt sits at the last location (DEPTH-1)
module array_fill_cnt
#(
    parameter int ADDRBIT = 9,
    parameter int DEPTH   = 512
)
(
    input  logic               wclk,
    input  logic               rst_,
    input  logic               en,
    input  logic               clr,
    output logic [ADDRBIT-1:0] cnt,
    output logic               wrap
);

    localparam logic [ADDRBIT-1:0] LAST_ADDR = ADDRBIT'(DEPTH - 1);

    assign wrap = (cnt == LAST_ADDR);

    // Fill address register: clear, advance with wrap, or hold.
    always_ff @(posedge wclk or negedge rst_) begin
        if (!rst_) begin
            cnt <= {ADDRBIT{1'b0}};
        end else if (clr) begin
            cnt <= {ADDRBIT{1'b0}};
        end else if (en) begin
            if (wrap) begin
                cnt <= {ADDRBIT{1'b0}};
            end else begin
                cnt <= cnt + {{(ADDRBIT-1){1'b0}}, 1'b1};
            end
        end else begin
            cnt <= cnt;
        end
    end

endmodule

// File: rtl/array_wr_ctrl.sv
// array_wr_ctrl: arbitrates writes into a DEPTH x WIDTH array.
//   Sources, in priority order: datapath engine (eng_*), initialisation fill
//   (init_*), CPU (cpu_*). At most one write launches per cycle and every
//   output is registered.
//   wclk, rst_          - clock (rising edge), async active-low reset
//   eng_vld/addr/wdat   - engine write strobe, address, data
//   cpu_req/addr/wdat   - CPU level request held until cpu_ack
//   cpu_ack, cpu_err    - CPU completion pulse, out-of-range flag with ack
//   init_req, init_pat  - fill-all-locations request and fill data
//   init_busy/done      - fill in progress, one-cycle completion pulse
//   par_clr_req/par_dis - parity sticky clear request, parity disable
//   wa, we, di          - array write port
//   par_ctrl            - [0] parity clear pulse, [1] parity disable
module array_wr_ctrl
    import array_pkg::*;
#(
    parameter int ADDRBIT = 9,
    parameter int DEPTH   = 512,
    parameter int WIDTH   = 32
)
(
    input  logic               wclk,
    input  logic               rst_,
    input  logic               eng_vld,
    input  logic [ADDRBIT-1:0] eng_addr,
    input  logic [WIDTH-1:0]   eng_wdat,
    input  logic               cpu_req,
    input  logic [ADDRBIT-1:0] cpu_addr,
    input  logic [WIDTH-1:0]   cpu_wdat,
    output logic               cpu_ack,
    output logic               cpu_err,
    input  logic               init_req,
    input  logic [WIDTH-1:0]   init_pat,
    output logic               init_busy,
    output logic               init_done,
    input  logic               par_clr_req,
    input  logic               par_dis,
    output logic [ADDRBIT-1:0] wa,
    output logic               we,
    output logic [WIDTH-1:0]   di,
    output logic [1:0]         par_ctrl
);

    localparam logic [ADDRBIT:0] DEPTH_W = (ADDRBIT+1)'(DEPTH);

    wr_state_e          state_r;
    wr_state_e          state_nxt_s;
    logic               ready_r;
    logic               fill_en_s;
    logic               fill_clr_s;
    logic [ADDRBIT-1:0] fill_cnt_s;
    logic               fill_wrap_s;
    logic               cpu_go_s;
    logic               eng_go_s;
    logic               eng_in_rng_s;
    logic               cpu_in_rng_s;

    logic               we_nxt_s;
    logic [ADDRBIT-1:0] wa_nxt_s;
    logic [WIDTH-1:0]   di_nxt_s;
    logic               ack_nxt_s;
    logic               err_nxt_s;
    logic               done_nxt_s;
    logic               busy_nxt_s;
    logic [1:0]         par_nxt_s;

    assign eng_in_rng_s = ({1'b0, eng_addr} < DEPTH_W);
    assign cpu_in_rng_s = ({1'b0, cpu_addr} < DEPTH_W);
    // ready_r holds off all launches on the first edge after reset release,
    // so the earliest write is taken on the second edge.
    assign eng_go_s     = ready_r & eng_vld;

    array_fill_cnt #(
        .ADDRBIT (ADDRBIT),
        .DEPTH   (DEPTH)
    ) u_fill_cnt (
        .wclk (wclk),
        .rst_ (rst_),
        .en   (fill_en_s),
        .clr  (fill_clr_s),
        .cnt  (fill_cnt_s),
        .wrap (fill_wrap_s)
    );

    // Post-reset launch enable.
    always_ff @(posedge wclk or negedge rst_) begin
        if (!rst_) begin
            ready_r <= 1'b0;
        end else begin
            ready_r <= 1'b1;
        end
    end

    // FSM state register.
    always_ff @(posedge wclk or negedge rst_) begin
        if (!rst_) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // FSM next state and fill/CPU launch decisions.
    always_comb begin
        state_nxt_s = state_r;
        fill_en_s   = 1'b0;
        fill_clr_s  = 1'b0;
        cpu_go_s    = 1'b0;
        if (ready_r) begin
            case (state_r)
                ST_IDLE: begin
                    if (init_req) begin
                        state_nxt_s = ST_INIT;
                        fill_clr_s  = 1'b1;
                    end else if (cpu_req && !eng_vld) begin
                        state_nxt_s = ST_CPU_ACK;
                        cpu_go_s    = 1'b1;
                    end else begin
                        state_nxt_s = ST_IDLE;
                    end
                end
                ST_INIT: begin
                    // An engine write steals the slot; the counter holds.
                    if (!eng_vld) begin
                        fill_en_s = 1'b1;
                        if (fill_wrap_s) begin
                            state_nxt_s = ST_IDLE;
                        end else begin
                            state_nxt_s = ST_INIT;
                        end
                    end else begin
                        state_nxt_s = ST_INIT;
                    end
                end
                ST_CPU_ACK: begin
                    state_nxt_s = ST_IDLE;
                end
                default: begin
                    state_nxt_s = ST_IDLE;
                end
            endcase
        end else begin
            state_nxt_s = ST_IDLE;
        end
    end

    // Next values of the registered write port and status outputs.
    always_comb begin
        we_nxt_s   = 1'b0;
        wa_nxt_s   = wa;
        di_nxt_s   = di;
        ack_nxt_s  = 1'b0;
        err_nxt_s  = 1'b0;
        done_nxt_s = 1'b0;
        if (eng_go_s) begin
            // Out-of-range engine writes are silently dropped.
            if (eng_in_rng_s) begin
                we_nxt_s = 1'b1;
                wa_nxt_s = eng_addr;
                di_nxt_s = eng_wdat;
            end else begin
                we_nxt_s = 1'b0;
            end
        end else if (fill_en_s) begin
            we_nxt_s   = 1'b1;
            wa_nxt_s   = fill_cnt_s;
            di_nxt_s   = init_pat;
            done_nxt_s = fill_wrap_s;
        end else if (cpu_go_s) begin
            we_nxt_s  = cpu_in_rng_s;
            wa_nxt_s  = cpu_addr;
            di_nxt_s  = cpu_wdat;
            ack_nxt_s = 1'b1;
            err_nxt_s = ~cpu_in_rng_s;
        end else begin
            we_nxt_s = 1'b0;
        end
        busy_nxt_s               = (state_nxt_s == ST_INIT);
        par_nxt_s                = 2'b00;
        par_nxt_s[PAR_CLR_BIT]   = par_clr_req | done_nxt_s;
        par_nxt_s[PAR_DIS_BIT]   = par_dis;
    end

    // Output registers.
    always_ff @(posedge wclk or negedge rst_) begin
        if (!rst_) begin
            we        <= 1'b0;
            wa        <= {ADDRBIT{1'b0}};
            di        <= {WIDTH{1'b0}};
            cpu_ack   <= 1'b0;
            cpu_err   <= 1'b0;
            init_busy <= 1'b0;
            init_done <= 1'b0;
            par_ctrl  <= 2'b00;
        end else begin
            we        <= we_nxt_s;
            wa        <= wa_nxt_s;
            di        <= di_nxt_s;
            cpu_ack   <= ack_nxt_s;
            cpu_err   <= err_nxt_s;
            init_busy <= busy_nxt_s;
            init_done <= done_nxt_s;
            par_ctrl  <= par_nxt_s;
        end
    end

endmodule

// File: tb/tb_array_wr_ctrl.sv
// tb_array_wr_ctrl: drives a default (DEPTH=512) and a DEPTH=300 instance
// with directed and random traffic and compares every cycle against a
// behavioural model of the write-arbitration rules.
module tb_array_wr_ctrl;

    logic        wclk = 1'b0;
    logic        rst_ = 1'b0;
    logic        eng_vld = 1'b0;
    logic [8:0]  eng_addr = 9'd0;
    logic [31:0] eng_wdat = 32'd0;
    logic        init_req = 1'b0;
    logic [31:0] init_pat = 32'd0;
    logic        par_clr_req = 1'b0;
    logic        par_dis = 1'b0;
    logic        cpu_req_v [2];
    logic [8:0]  cpu_addr_v [2];
    logic [31:0] cpu_wdat_v [2];

    logic        cpu_ack_v [2];
    logic        cpu_err_v [2];
    logic        busy_v [2];
    logic        done_v [2];
    logic [8:0]  wa_v [2];
    logic        we_v [2];
    logic [31:0] di_v [2];
    logic [1:0]  par_v [2];

    int errs = 0;
    int checks = 0;

    // model state and expectations, per instance
    int          dep [2] = '{512, 300};
    bit          m_fill [2];
    int          m_faddr [2];
    bit          m_ackw [2];
    bit          m_rdy [2];
    bit          e_we [2];
    logic [8:0]  e_wa [2];
    logic [31:0] e_di [2];
    bit          e_ack [2];
    bit          e_err [2];
    bit          e_busy [2];
    bit          e_done [2];
    logic [1:0]  e_par [2];

    int  n_we0, n_busy0, n_done0, n_eng0;
    bit  rand_hs = 1'b0;

    always #5 wclk = ~wclk;

    array_wr_ctrl u_dut0 (
        .wclk(wclk), .rst_(rst_),
        .eng_vld(eng_vld), .eng_addr(eng_addr), .eng_wdat(eng_wdat),
        .cpu_req(cpu_req_v[0]), .cpu_addr(cpu_addr_v[0]), .cpu_wdat(cpu_wdat_v[0]),
        .cpu_ack(cpu_ack_v[0]), .cpu_err(cpu_err_v[0]),
        .init_req(init_req), .init_pat(init_pat),
        .init_busy(busy_v[0]), .init_done(done_v[0]),
        .par_clr_req(par_clr_req), .par_dis(par_dis),
        .wa(wa_v[0]), .we(we_v[0]), .di(di_v[0]), .par_ctrl(par_v[0])
    );

    array_wr_ctrl #(.ADDRBIT(9), .DEPTH(300), .WIDTH(32)) u_dut1 (
        .wclk(wclk), .rst_(rst_),
        .eng_vld(eng_vld), .eng_addr(eng_addr), .eng_wdat(eng_wdat),
        .cpu_req(cpu_req_v[1]), .cpu_addr(cpu_addr_v[1]), .cpu_wdat(cpu_wdat_v[1]),
        .cpu_ack(cpu_ack_v[1]), .cpu_err(cpu_err_v[1]),
        .init_req(init_req), .init_pat(init_pat),
        .init_busy(busy_v[1]), .init_done(done_v[1]),
        .par_clr_req(par_clr_req), .par_dis(par_dis),
        .wa(wa_v[1]), .we(we_v[1]), .di(di_v[1]), .par_ctrl(par_v[1])
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset(input int k);
        m_fill[k] = 1'b0; m_faddr[k] = 0; m_ackw[k] = 1'b0; m_rdy[k] = 1'b0;
        e_we[k] = 1'b0; e_wa[k] = 9'd0; e_di[k] = 32'd0; e_ack[k] = 1'b0;
        e_err[k] = 1'b0; e_busy[k] = 1'b0; e_done[k] = 1'b0; e_par[k] = 2'b00;
    endtask

    // One clock edge of the reference behaviour for instance k.
    task automatic model_step(input int k);
        bit was_fill, was_ack;
        e_we[k] = 1'b0; e_ack[k] = 1'b0; e_err[k] = 1'b0; e_done[k] = 1'b0;
        e_par[k] = {par_dis, par_clr_req};
        if (!m_rdy[k]) begin
            m_rdy[k] = 1'b1;
        end else begin
            was_fill = m_fill[k];
            was_ack  = m_ackw[k];
            if (eng_vld && int'(eng_addr) < dep[k]) begin
                e_we[k] = 1'b1; e_wa[k] = eng_addr; e_di[k] = eng_wdat;
            end
            if (was_ack) begin
                m_ackw[k] = 1'b0;
            end else if (was_fill) begin
                if (!eng_vld) begin
                    e_we[k] = 1'b1; e_wa[k] = 9'(m_faddr[k]); e_di[k] = init_pat;
                    if (m_faddr[k] == dep[k] - 1) begin
                        m_fill[k] = 1'b0; m_faddr[k] = 0;
                        e_done[k] = 1'b1; e_par[k][0] = 1'b1;
                    end else begin
                        m_faddr[k] = m_faddr[k] + 1;
                    end
                end
            end else if (init_req) begin
                m_fill[k] = 1'b1; m_faddr[k] = 0;
            end else if (cpu_req_v[k] && !eng_vld) begin
                e_ack[k] = 1'b1;
                e_err[k] = (int'(cpu_addr_v[k]) >= dep[k]);
                if (!e_err[k]) begin
                    e_we[k] = 1'b1; e_wa[k] = cpu_addr_v[k]; e_di[k] = cpu_wdat_v[k];
                end
                m_ackw[k] = 1'b1;
            end
        end
        e_busy[k] = m_fill[k];
    endtask

    task automatic check_outputs(input int k);
        chk($sformatf("we%0d", k), we_v[k], e_we[k]);
        chk($sformatf("ack%0d", k), cpu_ack_v[k], e_ack[k]);
        chk($sformatf("err%0d", k), cpu_err_v[k], e_err[k]);
        chk($sformatf("busy%0d", k), busy_v[k], e_busy[k]);
        chk($sformatf("done%0d", k), done_v[k], e_done[k]);
        chk($sformatf("par%0d", k), par_v[k], e_par[k]);
        if (e_we[k]) begin
            chk($sformatf("wa%0d", k), wa_v[k], e_wa[k]);
            chk($sformatf("di%0d", k), di_v[k], e_di[k]);
        end
    endtask

    task automatic tick();
        @(posedge wclk);
        model_step(0);
        model_step(1);
        @(negedge wclk);
        check_outputs(0);
        check_outputs(1);
        if (we_v[0]) n_we0++;
        if (busy_v[0]) n_busy0++;
        if (done_v[0]) n_done0++;
        if (we_v[0] && di_v[0] == 32'hDEADBEEF) n_eng0++;
        if (rand_hs) begin
            for (int k = 0; k < 2; k++) begin
                if (cpu_req_v[k] && e_ack[k]) begin
                    cpu_req_v[k] = 1'b0;
                end else if (!cpu_req_v[k] && $urandom_range(0, 3) == 0) begin
                    cpu_req_v[k]  = 1'b1;
                    cpu_addr_v[k] = 9'($urandom);
                    cpu_wdat_v[k] = $urandom;
                end
            end
        end
    endtask

    task automatic clr_counts();
        n_we0 = 0; n_busy0 = 0; n_done0 = 0; n_eng0 = 0;
    endtask

    task automatic check_zero(input int k);
        chk($sformatf("rst_we%0d", k), we_v[k], 1'b0);
        chk($sformatf("rst_wa%0d", k), wa_v[k], 9'd0);
        chk($sformatf("rst_di%0d", k), di_v[k], 32'd0);
        chk($sformatf("rst_par%0d", k), par_v[k], 2'b00);
        chk($sformatf("rst_ack%0d", k), cpu_ack_v[k], 1'b0);
        chk($sformatf("rst_err%0d", k), cpu_err_v[k], 1'b0);
        chk($sformatf("rst_busy%0d", k), busy_v[k], 1'b0);
        chk($sformatf("rst_done%0d", k), done_v[k], 1'b0);
    endtask

    // Start a fill and run until instance 0 drops init_busy.
    task automatic run_fill(input int stall_at);
        int guard;
        clr_counts();
        init_req = 1'b1;
        tick();
        init_req = 1'b0;
        guard = 0;
        while (e_busy[0] && guard < 3000) begin
            if (stall_at > 0 && guard >= stall_at && guard < stall_at + 3) begin
                eng_vld = 1'b1; eng_addr = 9'd7; eng_wdat = 32'hDEADBEEF;
            end else begin
                eng_vld = 1'b0;
            end
            tick();
            guard++;
        end
        eng_vld = 1'b0;
        if (guard >= 3000) chk("fill_timeout", 1'b1, 1'b0);
        tick();
        tick();
    endtask

    initial begin
        for (int k = 0; k < 2; k++) begin
            cpu_req_v[k] = 1'b0; cpu_addr_v[k] = 9'd0; cpu_wdat_v[k] = 32'd0;
            model_reset(k);
        end
        repeat (3) @(posedge wclk);
        @(negedge wclk);
        check_zero(0);
        check_zero(1);
        rst_ = 1'b1;
        tick();
        tick();

        // full fill
        init_pat = 32'hA5A5A5A5;
        run_fill(0);
        chk("fill_writes", 64'(n_we0), 64'd512);
        chk("fill_busy", 64'(n_busy0), 64'd512);
        chk("fill_done", 64'(n_done0), 64'd1);

        // fill with a 3-cycle engine burst
        init_pat = 32'h0F0F0F0F;
        run_fill(50);
        chk("stall_writes", 64'(n_we0), 64'd515);
        chk("stall_eng", 64'(n_eng0), 64'd3);
        chk("stall_busy", 64'(n_busy0), 64'd515);
        chk("stall_done", 64'(n_done0), 64'd1);

        // CPU write in IDLE; out-of-range on the DEPTH=300 instance
        cpu_req_v[0] = 1'b1; cpu_addr_v[0] = 9'h010; cpu_wdat_v[0] = 32'h12345678;
        cpu_req_v[1] = 1'b1; cpu_addr_v[1] = 9'd300; cpu_wdat_v[1] = 32'hCAFEF00D;
        tick();
        chk("cpu_we", we_v[0], 1'b1);
        chk("cpu_wa", wa_v[0], 9'd16);
        chk("cpu_ack", cpu_ack_v[0], 1'b1);
        chk("oor_we", we_v[1], 1'b0);
        chk("oor_err", cpu_err_v[1], 1'b1);
        cpu_req_v[0] = 1'b0; cpu_req_v[1] = 1'b0;
        tick();
        chk("ackst_we", we_v[0], 1'b0);
        tick();

        // simultaneous engine and CPU
        eng_vld = 1'b1; eng_addr = 9'd5; eng_wdat = 32'h00001111;
        cpu_req_v[0] = 1'b1; cpu_addr_v[0] = 9'd20; cpu_wdat_v[0] = 32'h00002222;
        tick();
        chk("pri_eng_wa", wa_v[0], 9'd5);
        chk("pri_eng_ack", cpu_ack_v[0], 1'b0);
        eng_vld = 1'b0;
        tick();
        chk("pri_cpu_wa", wa_v[0], 9'd20);
        chk("pri_cpu_ack", cpu_ack_v[0], 1'b1);
        cpu_req_v[0] = 1'b0;
        tick();

        // reset in the middle of a fill
        begin
            int guard;
            init_req = 1'b1;
            tick();
            init_req = 1'b0;
            guard = 0;
            while (m_faddr[0] != 100 && guard < 1000) begin
                tick();
                guard++;
            end
            if (guard >= 1000) chk("abort_timeout", 1'b1, 1'b0);
        end
        rst_ = 1'b0;
        #1;
        model_reset(0);
        model_reset(1);
        check_zero(0);
        check_zero(1);
        @(posedge wclk);
        @(negedge wclk);
        rst_ = 1'b1;
        clr_counts();
        repeat (20) tick();
        chk("abort_no_writes", 64'(n_we0), 64'd0);
        chk("abort_no_busy", 64'(n_busy0), 64'd0);

        // random traffic
        rand_hs = 1'b1;
        for (int i = 0; i < 4000; i++) begin
            eng_vld     = ($urandom_range(0, 3) == 0);
            eng_addr    = 9'($urandom);
            eng_wdat    = $urandom;
            init_req    = ($urandom_range(0, 199) == 0);
            init_pat    = $urandom;
            par_clr_req = ($urandom_range(0, 9) == 0);
            par_dis     = 1'($urandom);
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
